universal_shift_register: RTL and testbench

//   WIDTH-bit universal shift register built from the rising-edge D flip-flop
//   and 2:1 mux cells of the gate-level library. Sits directly downstream of a
//   D flip-flop bank. Captures a parallel word and serialises it left or right,
//   or holds it. A shift counter flags when a full word has been shifted out.

---
 rtl/universal_shift_register.sv | 102 ++++++++++
 tb/tb_universal_shift_register.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - WIDTH-bit universal shift register with saturating shift counter
//
// Purpose:
//   Captures a parallel word and serialises it right or left, or holds it.
//   A saturating counter reports how many shifts have happened since the
//   last load or reset, and done flags a fully shifted-out word.
//
// Ports:
//   c     in   clock, rising edge
//   re_   in   asynchronous reset, active-low
//   s     in   [1:0] mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   d     in   [WIDTH-1:0] parallel load data
//   sil   in   serial in at the MSB on shift right
//   sir   in   serial in at the LSB on shift left
//   q     out  [WIDTH-1:0] register contents
//   q_    out  [WIDTH-1:0] complement of q
//   sor   out  serial out for right shifts (q[0])
//   sol   out  serial out for left shifts (q[WIDTH-1])
//   cnt   out  [CW-1:0] shifts since last load/reset, saturating at WIDTH
//   done  out  cnt == WIDTH
module universal_shift_register #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             c,
    input  logic             re_,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] d,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_,
    output logic             sor,
    output logic             sol,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cnt_full;

    assign cnt_full = (cnt_q == CNT_FULL);

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        case (s)
            MODE_RIGHT: begin
                data_d = {sil, data_q[WIDTH-1:1]};
                // Counter stops at WIDTH but the data keeps moving.
                if (!cnt_full) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MODE_LEFT: begin
                data_d = {data_q[WIDTH-2:0], sir};
                if (!cnt_full) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MODE_LOAD: begin
                data_d = d;
                cnt_d  = '0;
            end
            MODE_HOLD: begin
                data_d = data_q;
                cnt_d  = cnt_q;
            end
            default: begin
                data_d = data_q;
                cnt_d  = cnt_q;
            end
        endcase
    end

    always_ff @(posedge c or negedge re_) begin
        if (!re_) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // All outputs decode registered state only; no input reaches them combinationally.
    assign q    = data_q;
    assign q_   = ~data_q;
    assign sor  = data_q[0];
    assign sol  = data_q[WIDTH-1];
    assign cnt  = cnt_q;
    assign done = cnt_full;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - self-checking bench for universal_shift_register
module tb_universal_shift_register;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          c;
    logic          re_;
    logic [1:0]    s;
    logic [W-1:0]  d;
    logic          sil;
    logic          sir;
    logic [W-1:0]  q;
    logic [W-1:0]  q_;
    logic          sor;
    logic          sol;
    logic [CW-1:0] cnt;
    logic          done;

    int checks = 0;
    int errors = 0;
    bit clk_en = 1'b1;

    // Reference state kept as plain integers.
    int m_q   = 0;
    int m_cnt = 0;

    universal_shift_register #(.WIDTH(W), .CW(CW)) dut (
        .c    (c),
        .re_  (re_),
        .s    (s),
        .d    (d),
        .sil  (sil),
        .sir  (sir),
        .q    (q),
        .q_   (q_),
        .sor  (sor),
        .sol  (sol),
        .cnt  (cnt),
        .done (done)
    );

    initial c = 1'b0;
    always #5 if (clk_en) c = ~c;

    function automatic logic [13:0] exp_vec();
        int mask;
        int qn;
        mask = (1 << W) - 1;
        qn   = (~m_q) & mask;
        return {W'(m_q), W'(qn), 1'(m_q % 2), 1'((m_q >> (W - 1)) % 2),
                CW'(m_cnt), 1'(m_cnt == W)};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {q, q_, sor, sol, cnt, done};
    endfunction

    // Apply a mode for one edge and advance the reference from arithmetic rules.
    task automatic drive_edge(input logic [1:0] ms, input logic [W-1:0] md,
                              input logic msil, input logic msir);
        int mask;
        mask = (1 << W) - 1;
        s   = ms;
        d   = md;
        sil = msil;
        sir = msir;
        @(posedge c);
        #1;
        case (ms)
            2'b01: begin
                m_q   = (int'(msil) * (1 << (W - 1))) + (m_q / 2);
                m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
            end
            2'b10: begin
                m_q   = ((m_q * 2) + int'(msir)) & mask;
                m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
            end
            2'b11: begin
                m_q   = int'(md);
                m_cnt = 0;
            end
            default: ;
        endcase
    endtask

    task automatic async_reset_now();
        re_   = 1'b0;
        m_q   = 0;
        m_cnt = 0;
        #1;
    endtask

    task automatic test_reset();
        drive_edge(2'b11, 4'b1101, 1'b0, 1'b0);
        @(negedge c);
        clk_en = 1'b0;
        #2;
        async_reset_now();
        checks++;
        if ({q, q_, cnt, done} !== {4'b0000, 4'b1111, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_immediate: got q=%b q_=%b cnt=%0d done=%b, want 0000 1111 0 0",
                     q, q_, cnt, done);
        end
        clk_en = 1'b1;
        s = 2'b11;
        d = 4'b1111;
        repeat (2) @(posedge c);
        #1;
        checks++;
        if ({q, cnt} !== {4'b0000, 3'd0}) begin
            errors++;
            $display("FAIL reset_holds_edges: got q=%b cnt=%0d, want 0000 0", q, cnt);
        end
        #2;
        re_ = 1'b1;
    endtask

    task automatic test_load();
        drive_edge(2'b11, 4'b1011, 1'b0, 1'b0);
        checks++;
        if ({q, q_, sol, sor, cnt} !== {4'b1011, 4'b0100, 1'b1, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL load: got q=%b q_=%b sol=%b sor=%b cnt=%0d, want 1011 0100 1 1 0",
                     q, q_, sol, sor, cnt);
        end
    endtask

    task automatic test_shift_right();
        logic [3:0] sor_exp;
        sor_exp = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sor !== sor_exp[i]) begin
                errors++;
                $display("FAIL shift_right_sor[%0d]: got %b, want %b", i, sor, sor_exp[i]);
            end
            checks++;
            if (i > 0 && done !== 1'b0) begin
                errors++;
                $display("FAIL shift_right_early_done[%0d]: got %b, want 0", i, done);
            end
            drive_edge(2'b01, 4'b0000, 1'b0, 1'b0);
        end
        checks++;
        if ({q, cnt, done} !== {4'b0000, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL shift_right_end: got q=%b cnt=%0d done=%b, want 0000 4 1", q, cnt, done);
        end
    endtask

    task automatic test_shift_left_saturate();
        drive_edge(2'b11, 4'b0110, 1'b0, 1'b0);
        repeat (6) drive_edge(2'b10, 4'b0000, 1'b0, 1'b1);
        checks++;
        if ({q, cnt, done} !== {4'b1111, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL shift_left_sat: got q=%b cnt=%0d done=%b, want 1111 4 1", q, cnt, done);
        end
    endtask

    task automatic test_load_while_done();
        logic [13:0] snap;
        drive_edge(2'b11, 4'b0101, 1'b0, 1'b0);
        checks++;
        if ({q, cnt, done} !== {4'b0101, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL load_while_done: got q=%b cnt=%0d done=%b, want 0101 0 0", q, cnt, done);
        end
        snap = exp_vec();
        for (int i = 0; i < 3; i++) begin
            drive_edge(2'b00, W'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (dut_vec() !== snap) begin
                errors++;
                $display("FAIL hold[%0d]: got %b, want %b", i, dut_vec(), snap);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        drive_edge(2'b11, 4'b1110, 1'b0, 1'b0);
        repeat (2) drive_edge(2'b01, 4'b0000, 1'b1, 1'b0);
        #2;
        async_reset_now();
        checks++;
        if ({q, cnt, done} !== {4'b0000, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_shift: got q=%b cnt=%0d done=%b, want 0000 0 0", q, cnt, done);
        end
        re_ = 1'b1;
        drive_edge(2'b11, 4'b1001, 1'b0, 1'b0);
        checks++;
        if ({q, cnt} !== {4'b1001, 3'd0}) begin
            errors++;
            $display("FAIL load_after_reset: got q=%b cnt=%0d, want 1001 0", q, cnt);
        end
    endtask

    // Random modes with junk glitches on the inputs between edges.
    task automatic test_back_to_back();
        logic [1:0]   rs;
        logic [W-1:0] rd;
        logic         rl, rr;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #1;
                async_reset_now();
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL rand_reset[%0d]: got %b, want %b", i, dut_vec(), exp_vec());
                end
                re_ = 1'b1;
            end
            s   = 2'($urandom);
            d   = W'($urandom);
            sil = 1'($urandom);
            sir = 1'($urandom);
            #2;
            rs = 2'($urandom);
            rd = W'($urandom);
            rl = 1'($urandom);
            rr = 1'($urandom);
            drive_edge(rs, rd, rl, rr);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand[%0d] s=%b: got %b, want %b", i, rs, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        re_ = 1'b0;
        s   = 2'b00;
        d   = '0;
        sil = 1'b0;
        sir = 1'b0;
        #12;
        re_ = 1'b1;
        test_reset();
        test_load();
        test_shift_right();
        test_shift_left_saturate();
        test_load_while_done();
        test_reset_mid_shift();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
